// File: rtl/ps2_kbd_pkg.sv
// Shared constants, step encoding and FSM state type for the PS/2 keyboard init sequencer.
package ps2_kbd_pkg;

   localparam logic [7:0] CMD_RESET     = 8'hFF;
   localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
   localparam logic [7:0] CMD_LED       = 8'hED;
   localparam logic [7:0] CMD_ECHO      = 8'hEE;

   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

   localparam int unsigned TimerWidth = 26;

   typedef logic [2:0] step_t;

   localparam step_t StepReset     = 3'd0;
   localparam step_t StepTypematic = 3'd1;
   localparam step_t StepTypArg    = 3'd2;
   localparam step_t StepLed       = 3'd3;
   localparam step_t StepLedMask   = 3'd4;
   localparam step_t StepEcho      = 3'd5;

   typedef enum logic [2:0] {
      StStart,
      StSend,
      StWaitSent,
      StWaitAck,
      StWaitBat,
      StRetry,
      StReady,
      StError
   } state_e;

   typedef enum logic {
      LimResp,
      LimBat
   } limit_sel_e;

   function automatic logic [7:0] step_byte(step_t step, logic [7:0] typ_arg, logic [2:0] mask);
      logic [7:0] b;
      unique case (step)
         StepReset:     b = CMD_RESET;
         StepTypematic: b = CMD_TYPEMATIC;
         StepTypArg:    b = typ_arg;
         StepLed:       b = CMD_LED;
         StepLedMask:   b = {5'b0, mask};
         StepEcho:      b = CMD_ECHO;
         default:       b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ps2_resp_timer.sv
// Saturating response timer with a selectable limit (ACK response or BAT completion).
module ps2_resp_timer
   import ps2_kbd_pkg::*;
#(
   parameter int unsigned RespLimit = 2500000,
   parameter int unsigned BatLimit  = 50000000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       clear_i,
   input  limit_sel_e limit_sel_i,
   output logic       expired_o
);

   logic [TimerWidth-1:0] cnt_q, cnt_d;
   logic [TimerWidth-1:0] limit;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign limit     = (limit_sel_i == LimBat) ? TimerWidth'(BatLimit) : TimerWidth'(RespLimit);
   assign expired_o = (cnt_q >= limit);

endmodule

// File: rtl/ps2_kbd_init_seq.sv
// Keyboard init/LED command sequencer with scan-byte forwarding once configured.
// Optional echo probe before the reset command: define KBD_ECHO_PROBE_EN.
module ps2_kbd_init_seq
   import ps2_kbd_pkg::*;
#(
   parameter int unsigned RESP_TIMEOUT  = 2500000,
   parameter int unsigned BAT_TIMEOUT   = 50000000,
   parameter int unsigned MAX_RETRY     = 3,
   parameter logic [7:0]  TYPEMATIC_ARG = 8'h20
) (
   input  logic       clock,
   input  logic       resetn,
   output logic [7:0] cmd_out_o,
   output logic       cmd_send_o,
   input  logic       cmd_sent_i,
   input  logic       cmd_timeout_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   input  logic [2:0] led_mask_i,
   input  logic       led_update_i,
   output logic [7:0] scan_data_o,
   output logic       scan_valid_o,
   output logic       ready_o,
   output logic       init_error_o,
   output logic       busy_o
);

   localparam logic [1:0] MaxRetry = 2'(MAX_RETRY);

`ifdef KBD_ECHO_PROBE_EN
   localparam step_t StartStep = StepEcho;
`else
   localparam step_t StartStep = StepReset;
`endif

   state_e     state_q, state_d;
   step_t      step_q, step_d;
   logic [1:0] retry_q, retry_d;
   logic [7:0] cmd_q, cmd_d;
   logic [2:0] mask_q, mask_d;
   logic       pending_q, pending_d;
   logic [7:0] scan_data_q, scan_data_d;
   logic       scan_valid_q, scan_valid_d;
   logic       timer_expired;
   logic       step_led_issue;

   assign step_led_issue = (state_q == StSend) && (step_q == StepLed);

   ps2_resp_timer #(
      .RespLimit (RESP_TIMEOUT),
      .BatLimit  (BAT_TIMEOUT)
   ) u_timer (
      .clock       (clock),
      .resetn      (resetn),
      .clear_i     (state_d != state_q),
      .limit_sel_i ((state_q == StWaitBat) ? LimBat : LimResp),
      .expired_o   (timer_expired)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= StStart;
         step_q       <= StepReset;
         retry_q      <= '0;
         cmd_q        <= 8'h00;
         mask_q       <= '0;
         pending_q    <= 1'b0;
         scan_data_q  <= 8'h00;
         scan_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         retry_q      <= retry_d;
         cmd_q        <= cmd_d;
         mask_q       <= mask_d;
         pending_q    <= pending_d;
         scan_data_q  <= scan_data_d;
         scan_valid_q <= scan_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      retry_d = retry_q;
      unique case (state_q)
         StStart: begin
            step_d  = StartStep;
            retry_d = '0;
            state_d = StSend;
         end
         StSend: state_d = StWaitSent;
         StWaitSent: begin
            if (cmd_sent_i) begin
               state_d = StWaitAck;
            end else if (cmd_timeout_i) begin
               state_d = StRetry;
            end
         end
         StWaitAck: begin
`ifdef KBD_ECHO_PROBE_EN
            if (step_q == StepEcho) begin
               if (rx_valid_i && rx_data_i == CMD_ECHO) begin
                  retry_d = '0;
                  step_d  = StepReset;
                  state_d = StSend;
               end else if (rx_valid_i || timer_expired) begin
                  state_d = StRetry;
               end
            end else
`endif
            if (rx_valid_i && rx_data_i == RSP_ACK) begin
               retry_d = '0;
               if (step_q == StepReset) begin
                  state_d = StWaitBat;
               end else if (step_q == StepLedMask) begin
                  state_d = StReady;
               end else begin
                  step_d  = step_t'(step_q + 3'd1);
                  state_d = StSend;
               end
            end else if (rx_valid_i && rx_data_i == RSP_RESEND) begin
               state_d = StRetry;
            end else if (timer_expired) begin
               state_d = StRetry;
            end
         end
         StWaitBat: begin
            if (rx_valid_i && rx_data_i == RSP_BAT_OK) begin
               step_d  = StepTypematic;
               state_d = StSend;
            end else if ((rx_valid_i && rx_data_i == RSP_BAT_FAIL) || timer_expired) begin
               step_d  = StepReset;
               state_d = StRetry;
            end
         end
         StRetry: begin
            if (retry_q == MaxRetry) begin
               state_d = StError;
            end else begin
               retry_d = retry_q + 2'd1;
               state_d = StSend;
            end
         end
         StReady: begin
            if (led_update_i || pending_q) begin
               step_d  = StepLed;
               state_d = StSend;
            end
         end
         StError: state_d = StError;
         default: state_d = StStart;
      endcase
   end

   // Datapath: command byte is loaded on SEND entry so cmd_out is stable while cmd_send pulses.
   always_comb begin
      cmd_d        = cmd_q;
      mask_d       = mask_q;
      pending_d    = pending_q;
      scan_data_d  = scan_data_q;
      scan_valid_d = 1'b0;
      if (state_d == StSend && state_q != StSend) begin
         cmd_d = step_byte(step_d, TYPEMATIC_ARG, mask_q);
      end
      if (step_led_issue) begin
         mask_d    = led_mask_i;
         pending_d = 1'b0;
      end else if (led_update_i && state_q != StReady && state_q != StError) begin
         pending_d = 1'b1;
      end
      if (state_q == StReady && rx_valid_i) begin
         scan_data_d  = rx_data_i;
         scan_valid_d = 1'b1;
      end
   end

   always_comb begin
      cmd_send_o   = 1'b0;
      ready_o      = 1'b0;
      init_error_o = 1'b0;
      busy_o       = 1'b1;
      unique case (state_q)
         StSend: cmd_send_o = 1'b1;
         StReady: begin
            ready_o = 1'b1;
            busy_o  = 1'b0;
         end
         StError: begin
            init_error_o = 1'b1;
            busy_o       = 1'b0;
         end
         default: ;
      endcase
   end

   assign cmd_out_o    = cmd_q;
   assign scan_data_o  = scan_data_q;
   assign scan_valid_o = scan_valid_q;

endmodule

// File: tb/tb_ps2_kbd_init_seq.sv
// Self-checking bench: bench plays both the PS/2 controller and the keyboard.
module tb_ps2_kbd_init_seq;

   localparam int unsigned RespTo = 100;
   localparam int unsigned BatTo  = 300;
   localparam logic [7:0]  TypArg = 8'h20;

   logic       clock = 1'b0;
   logic       resetn;
   logic [7:0] cmd_out;
   logic       cmd_send;
   logic       cmd_sent;
   logic       cmd_timeout;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [2:0] led_mask;
   logic       led_update;
   logic [7:0] scan_data;
   logic       scan_valid;
   logic       ready;
   logic       init_error;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int scan_cnt = 0;

   always #5 clock = ~clock;

   ps2_kbd_init_seq #(
      .RESP_TIMEOUT  (RespTo),
      .BAT_TIMEOUT   (BatTo),
      .MAX_RETRY     (3),
      .TYPEMATIC_ARG (TypArg)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .cmd_out_o     (cmd_out),
      .cmd_send_o    (cmd_send),
      .cmd_sent_i    (cmd_sent),
      .cmd_timeout_i (cmd_timeout),
      .rx_data_i     (rx_data),
      .rx_valid_i    (rx_valid),
      .led_mask_i    (led_mask),
      .led_update_i  (led_update),
      .scan_data_o   (scan_data),
      .scan_valid_o  (scan_valid),
      .ready_o       (ready),
      .init_error_o  (init_error),
      .busy_o        (busy)
   );

   always @(posedge clock) begin
      #2;
      if (scan_valid === 1'b1) scan_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // Reference: the configuration byte list, straight from the command table.
   function automatic logic [7:0] model_byte(int step, logic [2:0] mask);
      logic [7:0] seq [5];
      seq[0] = 8'hFF;
      seq[1] = 8'hF3;
      seq[2] = TypArg;
      seq[3] = 8'hED;
      seq[4] = {5'b0, mask};
      return seq[step];
   endfunction

   function automatic logic [7:0] junk_byte();
      logic [7:0] v;
      do v = 8'($urandom_range(0, 255)); while (v == 8'hFA || v == 8'hFE);
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      resetn      = 1'b0;
      cmd_sent    = 1'b0;
      cmd_timeout = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      led_update  = 1'b0;
      led_mask    = 3'b000;
      tick(3);
      resetn = 1'b1;
   endtask

   // Returns x when no send strobe appears in the bound, so the caller's compare fails.
   task automatic get_cmd(output logic [7:0] b);
      b = 8'hxx;
      for (int i = 0; i < 2000; i++) begin
         if (cmd_send === 1'b1) begin
            b = cmd_out;
            return;
         end
         @(negedge clock);
      end
   endtask

   task automatic pulse_sent(output time t);
      tick($urandom_range(1, 3));
      cmd_sent = 1'b1;
      t = $time;
      @(negedge clock);
      cmd_sent = 1'b0;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      tick($urandom_range(1, 3));
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic run_init(input logic [2:0] mask);
      logic [7:0] b;
      time t;
      led_mask = mask;
      for (int s = 0; s < 5; s++) begin
         get_cmd(b);
         pulse_sent(t);
         pulse_rx(8'hFA);
         if (s == 0) pulse_rx(8'hAA);
      end
   endtask

   task automatic test_reset();
      do_reset();
      resetn = 1'b0;
      tick(2);
      checks++; if (cmd_out !== 8'h00) begin failures++; $display("FAIL reset_cmd_out: got %h want 00", cmd_out); end
      checks++; if (cmd_send !== 1'b0) begin failures++; $display("FAIL reset_cmd_send: got %b want 0", cmd_send); end
      checks++; if (scan_valid !== 1'b0) begin failures++; $display("FAIL reset_scan_valid: got %b want 0", scan_valid); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready); end
      checks++; if (init_error !== 1'b0) begin failures++; $display("FAIL reset_init_error: got %b want 0", init_error); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b want 1", busy); end
      resetn = 1'b1;
   endtask

   task automatic test_nominal();
      logic [7:0] b;
      time t;
      int sc0;
      do_reset();
      sc0 = scan_cnt;
      for (int s = 0; s < 5; s++) begin
         get_cmd(b);
         checks++;
         if (b !== model_byte(s, 3'b000)) begin
            failures++; $display("FAIL nominal_byte%0d: got %h want %h", s, b, model_byte(s, 3'b000));
         end
         pulse_sent(t);
         if ($urandom_range(0, 1) == 1) pulse_rx(junk_byte());
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL nominal_busy%0d: got %b want 1", s, busy); end
         pulse_rx(8'hFA);
         if (s == 0) pulse_rx(8'hAA);
      end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL nominal_ready: got %b want 1", ready); end
      checks++; if (init_error !== 1'b0) begin failures++; $display("FAIL nominal_err: got %b want 0", init_error); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nominal_idle: got %b want 0", busy); end
      checks++; if (scan_cnt != sc0) begin failures++; $display("FAIL nominal_noforward: got %0d want %0d", scan_cnt, sc0); end
   endtask

   task automatic test_nak();
      logic [7:0] b;
      logic [7:0] rsp [6];
      int         stp [6];
      logic [2:0] m;
      time t;
      do_reset();
      m = 3'($urandom_range(0, 7));
      led_mask = m;
      stp = '{0, 1, 1, 2, 3, 4};
      rsp = '{8'hFA, 8'hFE, 8'hFA, 8'hFA, 8'hFA, 8'hFA};
      for (int k = 0; k < 6; k++) begin
         get_cmd(b);
         checks++;
         if (b !== model_byte(stp[k], m)) begin
            failures++; $display("FAIL nak_byte%0d: got %h want %h", k, b, model_byte(stp[k], m));
         end
         pulse_sent(t);
         pulse_rx(rsp[k]);
         if (k == 0) pulse_rx(8'hAA);
      end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL nak_ready: got %b want 1", ready); end
      checks++; if (dut.retry_q !== 2'd0) begin failures++; $display("FAIL nak_retry_clr: got %0d want 0", dut.retry_q); end
   endtask

   task automatic test_fail();
      logic [7:0] b;
      time t;
      int gap, n, sc0;
      do_reset();
      led_mask = 3'($urandom_range(0, 7));
      get_cmd(b);
      checks++; if (b !== 8'hFF) begin failures++; $display("FAIL fail_first: got %h want ff", b); end
      for (int k = 0; k < 3; k++) begin
         pulse_sent(t);
         get_cmd(b);
         gap = int'(($time - t) / 10);
         checks++; if (b !== 8'hFF) begin failures++; $display("FAIL fail_resend%0d: got %h want ff", k, b); end
         checks++;
         if (gap < int'(RespTo) || gap > int'(RespTo) + 5) begin
            failures++; $display("FAIL fail_gap%0d: got %0d cycles want %0d..%0d", k, gap, RespTo, RespTo + 5);
         end
      end
      pulse_sent(t);
      n = 0;
      for (int i = 0; i < int'(RespTo) + 30; i++) begin
         @(negedge clock);
         if (cmd_send === 1'b1) n++;
      end
      checks++; if (n != 0) begin failures++; $display("FAIL fail_extra_send: got %0d want 0", n); end
      checks++; if (init_error !== 1'b1) begin failures++; $display("FAIL fail_err: got %b want 1", init_error); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL fail_ready: got %b want 0", ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fail_busy: got %b want 0", busy); end
      sc0 = scan_cnt;
      pulse_rx(8'h1C);
      tick(2);
      checks++; if (scan_cnt != sc0) begin failures++; $display("FAIL fail_noforward: got %0d want %0d", scan_cnt, sc0); end
   endtask

   task automatic test_bat_fail();
      logic [7:0] b;
      logic [2:0] m;
      time t;
      do_reset();
      m = 3'($urandom_range(0, 7));
      led_mask = m;
      get_cmd(b);
      checks++; if (b !== 8'hFF) begin failures++; $display("FAIL bat_first: got %h want ff", b); end
      pulse_sent(t);
      pulse_rx(8'hFA);
      pulse_rx(8'hFC);
      for (int s = 0; s < 5; s++) begin
         get_cmd(b);
         checks++;
         if (b !== model_byte(s, m)) begin
            failures++; $display("FAIL bat_byte%0d: got %h want %h", s, b, model_byte(s, m));
         end
         pulse_sent(t);
         pulse_rx(8'hFA);
         if (s == 0) pulse_rx(8'hAA);
      end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL bat_ready: got %b want 1", ready); end
      checks++; if (init_error !== 1'b0) begin failures++; $display("FAIL bat_err: got %b want 0", init_error); end
   endtask

   task automatic test_runtime_led();
      logic [7:0] b, d;
      time t;
      int sc0;
      do_reset();
      run_init(3'($urandom_range(0, 7)));
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL led_init_ready: got %b want 1", ready); end
      for (int k = 0; k < 6; k++) begin
         d = 8'($urandom_range(0, 255));
         pulse_rx(d);
         checks++;
         if (scan_valid !== 1'b1 || scan_data !== d) begin
            failures++; $display("FAIL fwd%0d: got v=%b d=%h want v=1 d=%h", k, scan_valid, scan_data, d);
         end
         @(negedge clock);
         checks++; if (scan_valid !== 1'b0) begin failures++; $display("FAIL fwd_pulse%0d: got %b want 0", k, scan_valid); end
      end
      led_mask   = 3'b101;
      led_update = 1'b1;
      @(negedge clock);
      led_update = 1'b0;
      sc0 = scan_cnt;
      get_cmd(b);
      checks++; if (b !== model_byte(3, 3'b101)) begin failures++; $display("FAIL led_cmd: got %h want ed", b); end
      pulse_sent(t);
      pulse_rx(8'h1C);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL led_busy: got %b want 1", busy); end
      pulse_rx(8'hFA);
      get_cmd(b);
      checks++; if (b !== model_byte(4, 3'b101)) begin failures++; $display("FAIL led_mask: got %h want 05", b); end
      pulse_sent(t);
      pulse_rx(8'hFA);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL led_ready: got %b want 1", ready); end
      checks++; if (scan_cnt != sc0) begin failures++; $display("FAIL led_noforward: got %0d want %0d", scan_cnt, sc0); end
      pulse_rx(8'h1C);
      checks++;
      if (scan_valid !== 1'b1 || scan_data !== 8'h1C) begin
         failures++; $display("FAIL led_fwd_after: got v=%b d=%h want v=1 d=1c", scan_valid, scan_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b, d;
      logic [2:0] ma, mb;
      time t;
      do_reset();
      run_init(3'($urandom_range(0, 7)));
      ma = 3'($urandom_range(0, 7));
      mb = 3'($urandom_range(0, 7));
      d  = 8'($urandom_range(0, 255));
      led_mask   = ma;
      rx_data    = d;
      rx_valid   = 1'b1;
      led_update = 1'b1;
      @(negedge clock);
      rx_valid   = 1'b0;
      led_update = 1'b0;
      checks++;
      if (scan_valid !== 1'b1 || scan_data !== d) begin
         failures++; $display("FAIL b2b_fwd: got v=%b d=%h want v=1 d=%h", scan_valid, scan_data, d);
      end
      get_cmd(b);
      checks++; if (b !== 8'hED) begin failures++; $display("FAIL b2b_cmd1: got %h want ed", b); end
      pulse_sent(t);
      led_mask   = mb;
      led_update = 1'b1;
      @(negedge clock);
      led_update = 1'b0;
      pulse_rx(8'hFA);
      get_cmd(b);
      checks++; if (b !== model_byte(4, ma)) begin failures++; $display("FAIL b2b_mask1: got %h want %h", b, model_byte(4, ma)); end
      pulse_sent(t);
      pulse_rx(8'hFA);
      get_cmd(b);
      checks++; if (b !== 8'hED) begin failures++; $display("FAIL b2b_cmd2: got %h want ed", b); end
      pulse_sent(t);
      pulse_rx(8'hFA);
      get_cmd(b);
      checks++; if (b !== model_byte(4, mb)) begin failures++; $display("FAIL b2b_mask2: got %h want %h", b, model_byte(4, mb)); end
      pulse_sent(t);
      pulse_rx(8'hFA);
      tick(4);
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_settle: got r=%b b=%b want r=1 b=0", ready, busy); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      time t;
      do_reset();
      led_mask = 3'($urandom_range(0, 7));
      for (int s = 0; s < 2; s++) begin
         get_cmd(b);
         pulse_sent(t);
         pulse_rx(8'hFA);
         if (s == 0) pulse_rx(8'hAA);
      end
      get_cmd(b);
      checks++; if (b !== TypArg) begin failures++; $display("FAIL mid_arg: got %h want %h", b, TypArg); end
      pulse_sent(t);
      resetn = 1'b0;
      @(negedge clock);
      checks++;
      if (cmd_out !== 8'h00 || cmd_send !== 1'b0 || scan_valid !== 1'b0 || ready !== 1'b0 ||
          init_error !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_vals: got out=%h snd=%b sv=%b rdy=%b err=%b bsy=%b want 00 0 0 0 0 1",
                  cmd_out, cmd_send, scan_valid, ready, init_error, busy);
      end
      tick(1);
      resetn = 1'b1;
      get_cmd(b);
      checks++; if (b !== 8'hFF) begin failures++; $display("FAIL mid_restart: got %h want ff", b); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_nak();
      test_fail();
      test_bat_fail();
      test_runtime_led();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
